serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/full_adder.sv | 14 +
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the default operand width.
package serial_add_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder. This is the only arithmetic element
// in the serial datapath.
module full_adder (
   input  logic A_in,
   input  logic B_in,
   input  logic C_in,
   output logic sum_out,
   output logic c_out
);

   assign sum_out = A_in ^ B_in ^ C_in;
   assign c_out   = (A_in & B_in) | (A_in & C_in) | (B_in & C_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Operands are latched when start is accepted,
// then summed LSB first, one bit per clock, through a single full adder.
// Optional macro SERIAL_ADD_OVF_EN adds a registered two's-complement
// overflow output, ovf_out.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last sum
// RUN   | one operand bit added per cycle, WIDTH cycles in total
// DONE  | one-cycle result-valid; start here chains straight into RUN
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic             C_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf_out
`endif
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic             fa_sum;
   logic             fa_cout;
   logic             accept;
   logic             last_bit;

   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign last_bit = (state == RUN) && (bit_cnt == LAST_BIT);

   full_adder u_fa (
      .A_in    (a_sh[0]),
      .B_in    (b_sh[0]),
      .C_in    (carry),
      .sum_out (fa_sum),
      .c_out   (fa_cout)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // next-state decode; start is only looked at outside RUN
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (bit_cnt == LAST_BIT) next_state = DONE;
         DONE:    next_state = start ? RUN : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Moore outputs
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // operand shifters: sum bits enter a_sh from the top as operand bits
   // leave at the bottom, so a_sh holds the partial sum by the end of RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         carry   <= 1'b0;
         bit_cnt <= '0;
      end else if (accept) begin
         a_sh    <= A_in;
         b_sh    <= B_in;
         carry   <= C_in;
         bit_cnt <= '0;
      end else if (state == RUN) begin
         a_sh  <= {fa_sum, a_sh[WIDTH-1:1]};
         b_sh  <= b_sh >> 1;
         carry <= fa_cout;
         if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
      end
   end

   // result registers, loaded only on the edge that enters DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_out <= '0;
         c_out   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_out <= 1'b0;
`endif
      end else if (last_bit) begin
         sum_out <= {fa_sum, a_sh[WIDTH-1:1]};
         c_out   <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
         // carry is the carry into the MSB during the final bit
         ovf_out <= carry ^ fa_cout;
`endif
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit instance for directed
// and random operations, a 4-bit instance for the full operand space.
// Expected results come from plain integer arithmetic.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       start8;
   logic [7:0] a8, b8;
   logic       c8;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start4;
   logic [3:0] a4, b4;
   logic       c4;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;

`ifdef SERIAL_ADD_OVF_EN
   logic       ovf8, ovf4;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start8),
      .A_in    (a8),
      .B_in    (b8),
      .C_in    (c8),
      .busy    (busy8),
      .done    (done8),
      .sum_out (sum8),
      .c_out   (cout8)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf_out (ovf8)
`endif
   );

   serial_adder_ctrl #(.WIDTH(4)) dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start4),
      .A_in    (a4),
      .B_in    (b4),
      .C_in    (c4),
      .busy    (busy4),
      .done    (done4),
      .sum_out (sum4),
      .c_out   (cout4)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf_out (ovf4)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_checks++;
      if (obs === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
   endtask

   // signed overflow: true signed sum of the operands leaves the w-bit range
   function automatic bit ref_ovf(input int w, input int a, input int b, input int c);
      int half, sa, sb, t;
      half = 1 << (w - 1);
      sa   = (a >= half) ? a - 2 * half : a;
      sb   = (b >= half) ? b - 2 * half : b;
      t    = sa + sb + c;
      return (t >= half) || (t < -half);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n = edges after the start-sampling edge until done is seen
   task automatic wait_done8(output int n, output int nb);
      n  = 0;
      nb = 0;
      while (!done8 && n < 40) begin
         if (busy8) nb++;
         tick();
         n++;
      end
      if (!done8) chk("done8_timeout", 64'd0, 64'd1);
   endtask

   // mode 0: operands held, 1: operands zeroed during RUN, 2: randomized
   task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int mode);
      logic [8:0] want;
      int n, nb;
      want   = 9'(a) + 9'(b) + 9'(c);
      start8 = 1'b1;
      a8 = a; b8 = b; c8 = c;
      tick();
      start8 = 1'b0;
      if (mode == 1) begin
         a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
      end else if (mode == 2) begin
         a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end
      wait_done8(n, nb);
      // done after WIDTH more edges: WIDTH+1 edges counting the sampling edge
      chk("latency8", 64'(n), 64'd8);
      chk("busy_cycles8", 64'(nb), 64'd8);
      chk("sum8", 64'(sum8), 64'(want[7:0]));
      chk("cout8", 64'(cout8), 64'(want[8]));
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf8", 64'(ovf8), 64'(ref_ovf(8, int'(a), int'(b), int'(c))));
`endif
      chk("busy_low_at_done8", 64'(busy8), 64'd0);
      tick();
      chk("done_one_cycle8", 64'(done8), 64'd0);
      chk("sum8_held", 64'(sum8), 64'(want[7:0]));
   endtask

   task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic c);
      logic [4:0] want;
      int n;
      want   = 5'(a) + 5'(b) + 5'(c);
      start4 = 1'b1;
      a4 = a; b4 = b; c4 = c;
      tick();
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      n = 0;
      while (!done4 && n < 20) begin
         tick();
         n++;
      end
      chk("latency4", 64'(n), 64'd4);
      chk("sum4", 64'({cout4, sum4}), 64'(want));
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf4", 64'(ovf4), 64'(ref_ovf(4, int'(a), int'(b), int'(c))));
`endif
      tick();
   endtask

   initial begin
      int first_k, second_k, dcount;
      logic [7:0] s1, s2;
      int order[512];

      rst_n  = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_sum", 64'(sum8), 64'd0);
      chk("rst_cout", 64'(cout8), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf", 64'(ovf8), 64'd0);
`endif

      // start is raised together with reset release: first edge must take it
      rst_n = 1'b1;
      run_op8(8'hFF, 8'h01, 1'b0, 0);
      run_op8(8'h5A, 8'h35, 1'b1, 1);
      chk("dir_5a35_sum", 64'(sum8), 64'h90);
`ifdef SERIAL_ADD_OVF_EN
      run_op8(8'h7F, 8'h01, 1'b0, 0);
      chk("dir_7f01_ovf", 64'(ovf8), 64'd1);
      run_op8(8'hFF, 8'h01, 1'b0, 0);
      chk("dir_ff01_ovf", 64'(ovf8), 64'd0);
`endif

      // back-to-back: start held high, second operand pair set during RUN
      start8 = 1'b1;
      a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
      tick();
      a8 = 8'h02; b8 = 8'h02;
      first_k = 0; second_k = 0; s1 = '0; s2 = '0;
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (done8) begin
            if (first_k == 0) begin
               first_k = k; s1 = sum8;
            end else begin
               second_k = k; s2 = sum8;
            end
         end
         if (k == 9) chk("b2b_busy_no_gap", 64'(busy8), 64'd1);
      end
      start8 = 1'b0;
      chk("b2b_first_done", 64'(first_k), 64'd8);
      chk("b2b_second_done", 64'(second_k), 64'd17);
      chk("b2b_sum1", 64'(s1), 64'h02);
      chk("b2b_sum2", 64'(s2), 64'h04);
      tick();
      chk("b2b_idle_busy", 64'(busy8), 64'd0);
      chk("b2b_idle_done", 64'(done8), 64'd0);

      // reset during RUN, with non-zero result registers beforehand
      run_op8(8'hF0, 8'h20, 1'b1, 0);
      start8 = 1'b1;
      a8 = 8'h33; b8 = 8'h44; c8 = 1'b0;
      tick();
      start8 = 1'b0;
      repeat (4) tick();
      chk("midrun_busy_pre", 64'(busy8), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_busy", 64'(busy8), 64'd0);
      chk("midrun_rst_done", 64'(done8), 64'd0);
      chk("midrun_rst_sum", 64'(sum8), 64'd0);
      chk("midrun_rst_cout", 64'(cout8), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done8) dcount++;
      end
      chk("midrun_no_done", 64'(dcount), 64'd0);
      run_op8(8'h33, 8'h44, 1'b0, 0);

      for (int i = 0; i < 25; i++)
         run_op8(8'($urandom), 8'($urandom), 1'($urandom), 2);

      // all 512 operand/carry combinations at WIDTH=4, in shuffled order
      for (int i = 0; i < 512; i++) order[i] = i;
      for (int i = 511; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(i, 0));
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 512; i++)
         run_op4(4'(order[i]), 4'(order[i] >> 4), 1'(order[i] >> 8));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
